// File: rtl/pc_unit_btb.sv
// Fetch-address unit: PC register, direct-mapped BTB with 2-bit counters,
// ID-stage branch/jump resolution with mispredict redirect, eret/interrupt
// redirects and stall hold.
module pc_unit_btb #(
  parameter int          BTB_IDX_W  = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_3008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        eret,
  input  logic        pcint,
  input  logic [31:0] epc,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        id_pred_taken,
  input  logic [31:0] id_pred_target,
  input  logic        Branch,
  input  logic        equ,
  input  logic        Jump,
  input  logic        JumpR,
  input  logic [31:0] imme32,
  input  logic [25:0] target,
  input  logic [31:0] rs_real,
  output logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        flush,
  output logic [31:0] mispredict_cnt
);

  localparam int ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W   = 32 - BTB_IDX_W - 2;

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] cnt_reg;
  logic [31:0] pc_plus4;

  // Per-entry views of the BTB storage (driven from the generate block below)
  logic             valid_arr  [ENTRIES];
  logic [TAG_W-1:0] tag_arr    [ENTRIES];
  logic [31:0]      target_arr [ENTRIES];
  logic [1:0]       ctr_arr    [ENTRIES];

  // Lookup side
  logic [BTB_IDX_W-1:0] look_idx;
  logic [TAG_W-1:0]     look_tag;
  logic                 look_hit;

  // Resolution side
  logic                 res;
  logic                 mis;
  logic                 actual_taken;
  logic [31:0]          actual_target;
  logic [31:0]          id_pc_plus4;
  logic [31:0]          correct_pc;
  logic [BTB_IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0]     upd_tag;
  logic                 upd_hit;
  logic                 upd_en;
  logic                 ent_wr;
  logic                 ctr_wr;
  logic [1:0]           ctr_new;

  assign pc             = pc_reg;
  assign mispredict_cnt = cnt_reg;
  assign pc_plus4       = pc_reg + 32'd4;

  // BTB lookup on the current fetch PC; reads only registered state, so an
  // update to the same index this cycle is not visible until the next one
  always_comb begin
    look_idx    = pc_reg[BTB_IDX_W+1:2];
    look_tag    = pc_reg[31:BTB_IDX_W+2];
    look_hit    = valid_arr[look_idx] && (tag_arr[look_idx] == look_tag);
    pred_taken  = look_hit && ctr_arr[look_idx][1];
    pred_target = pred_taken ? target_arr[look_idx] : pc_plus4;
  end

  // ID-stage resolution and mispredict detection
  always_comb begin
    id_pc_plus4  = id_pc + 32'd4;
    res          = id_valid && !stall && (Branch || Jump);
    actual_taken = Jump || (Branch && equ);
    if (JumpR) begin
      actual_target = rs_real;
    end else if (Jump) begin
      actual_target = {id_pc[31:28], target, 2'b00};
    end else begin
      actual_target = id_pc_plus4 + (imme32 << 2);
    end
    // A predicted-taken non-branch falls out naturally: actual_taken is 0
    mis = id_valid && !stall &&
          ((actual_taken != id_pred_taken) ||
           (actual_taken && (id_pred_target != actual_target)));
    correct_pc = actual_taken ? actual_target : id_pc_plus4;
    flush      = eret || pcint || mis;
  end

  // Next-PC selection, highest priority first
  always_comb begin
    pc_next = pred_target;
    if (eret) begin
      pc_next = epc;
    end else if (pcint) begin
      pc_next = INT_VECTOR;
    end else if (mis) begin
      pc_next = correct_pc;
    end else if (stall) begin
      pc_next = pc_reg;
    end
  end

  // BTB write decision for the resolving instruction (indexed by id_pc)
  always_comb begin
    upd_idx = id_pc[BTB_IDX_W+1:2];
    upd_tag = id_pc[31:BTB_IDX_W+2];
    upd_hit = valid_arr[upd_idx] && (tag_arr[upd_idx] == upd_tag);
    upd_en  = res && !eret && !pcint;
    ent_wr  = 1'b0;
    ctr_wr  = 1'b0;
    ctr_new = ctr_arr[upd_idx];
    if (upd_en) begin
      if (Jump) begin
        // Register jumps are never cached; their target is data-dependent
        if (!JumpR) begin
          ent_wr  = 1'b1;
          ctr_wr  = 1'b1;
          ctr_new = 2'b11;
        end
      end else if (Branch) begin
        if (upd_hit) begin
          ctr_wr = 1'b1;
          if (equ) begin
            ent_wr  = 1'b1;
            ctr_new = (ctr_arr[upd_idx] == 2'b11) ? 2'b11 : ctr_arr[upd_idx] + 2'b01;
          end else begin
            ctr_new = (ctr_arr[upd_idx] == 2'b00) ? 2'b00 : ctr_arr[upd_idx] - 2'b01;
          end
        end else if (equ) begin
          ent_wr  = 1'b1;
          ctr_wr  = 1'b1;
          ctr_new = 2'b10;
        end
      end
    end
  end

  // BTB entries: async reset invalidates everything and sets weakly-not-taken
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_ent
      logic             valid_reg;
      logic [TAG_W-1:0] tag_reg;
      logic [31:0]      target_reg;
      logic [1:0]       ctr_reg;
      logic             sel;

      assign sel = (upd_idx == BTB_IDX_W'(gi));

      // Entry storage update on a selected write
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg  <= 1'b0;
          tag_reg    <= '0;
          target_reg <= '0;
          ctr_reg    <= 2'b01;
        end else if (sel) begin
          if (ent_wr) begin
            valid_reg  <= 1'b1;
            tag_reg    <= upd_tag;
            target_reg <= actual_target;
          end
          if (ctr_wr) begin
            ctr_reg <= ctr_new;
          end
        end
      end

      assign valid_arr[gi]  = valid_reg;
      assign tag_arr[gi]    = tag_reg;
      assign target_arr[gi] = target_reg;
      assign ctr_arr[gi]    = ctr_reg;
    end
  endgenerate

  // PC register and saturating mispredict counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg  <= RESET_PC;
      cnt_reg <= '0;
    end else begin
      pc_reg <= pc_next;
      if (mis && !eret && !pcint && (cnt_reg != 32'hFFFF_FFFF)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

endmodule
